// File: rtl/key_evt_arb_if.sv
// Handshake and status bundle between the key-event arbiter and its consumer.
// master drives the requests/ready/clear; slave (the arbiter) drives the event and flags.
interface key_evt_arb_if;
    logic [3:0] key_pulse;
    logic       evt_ready;
    logic       ovf_clr;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic       busy;

    modport master (
        output key_pulse,
        output evt_ready,
        output ovf_clr,
        input  evt_valid,
        input  evt_code,
        input  pend,
        input  ovf,
        input  busy
    );

    modport slave (
        input  key_pulse,
        input  evt_ready,
        input  ovf_clr,
        output evt_valid,
        output evt_code,
        output pend,
        output ovf,
        output busy
    );
endinterface

// File: rtl/key_evt_arb.sv
// Round-robin arbiter that turns one-cycle key pulses into valid/ready events,
// with sticky overflow flags and an enforced idle gap after each accepted event.
module key_evt_arb #(
    parameter int unsigned N_KEYS     = 4,
    parameter int unsigned GAP_CYCLES = 9000
) (
    input logic          clk,
    input logic          rst_n,
    key_evt_arb_if.slave bus
);

    localparam int unsigned CW = $clog2(N_KEYS);
    localparam logic [31:0] GAP_LAST = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       code_q, code_d;
    logic [CW-1:0]       last_q, last_d;
    logic [N_KEYS-1:0]   pend_q, pend_d;
    logic [N_KEYS-1:0]   ovf_q, ovf_d;
    logic [31:0]         gap_q, gap_d;

    logic                hs;
    logic [N_KEYS-1:0]   served;
    logic [N_KEYS-1:0]   ovf_set;
    logic [CW-1:0]       rr_cand;
    logic [CW-1:0]       rr_idx;
    logic                rr_found;

    // A handshake can only exist while the event is actually presented.
    assign hs      = (state_q == VALID) && bus.evt_ready;
    assign served  = hs ? (N_KEYS'(1) << code_q) : '0;

    // A press arriving in the serving cycle re-arms the flag; any other
    // press onto a still-pending key is dropped and flagged.
    assign pend_d  = (pend_q & ~served) | bus.key_pulse;
    assign ovf_set = bus.key_pulse & pend_q & ~served;
    assign ovf_d   = (bus.ovf_clr ? '0 : ovf_q) | ovf_set;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no
        // path leaves it holding its old value and no latch is inferred.
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            rr_cand = last_q + CW'(k + 1);
            if (!rr_found && pend_q[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        last_d  = last_q;
        gap_d   = 32'd0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d = VALID;
                    code_d  = rr_idx;
                end
            end
            VALID: begin
                if (bus.evt_ready) begin
                    last_d  = code_q;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            last_q  <= CW'(N_KEYS - 1);
            pend_q  <= '0;
            ovf_q   <= '0;
            gap_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.evt_valid = (state_q == VALID);
    assign bus.evt_code  = code_q;
    assign bus.pend      = pend_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_key_evt_arb.sv
// Randomised and directed bench for key_evt_arb: a behavioural model predicts
// flags and events; a negedge monitor compares every cycle and scoreboards events.
module tb_key_evt_arb;

    localparam int GAP = 4;

    logic clk = 1'b0;
    logic rst_n;

    key_evt_arb_if bus ();

    key_evt_arb #(
        .N_KEYS    (4),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural model: flags as bit vectors, control as "presenting" plus a gap countdown.
    logic [3:0] m_pend    = 4'b0;
    logic [3:0] m_ovf     = 4'b0;
    bit         m_present = 1'b0;
    int         m_code    = 0;
    int         m_last    = 3;
    int         m_gap_left = 0;

    logic [3:0] nxt_pend;
    bit         m_hs;
    bit         m_served;
    int         pick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_pend     = 4'b0;
            m_ovf      = 4'b0;
            m_present  = 1'b0;
            m_code     = 0;
            m_last     = 3;
            m_gap_left = 0;
        end else begin
            m_hs = m_present && bus.evt_ready;
            for (int i = 0; i < 4; i++) begin
                m_served    = m_hs && (m_code == i);
                nxt_pend[i] = (m_pend[i] && !m_served) || bus.key_pulse[i];
                m_ovf[i]    = (bus.ovf_clr ? 1'b0 : m_ovf[i])
                              || (bus.key_pulse[i] && m_pend[i] && !m_served);
            end
            if (m_present) begin
                if (m_hs) begin
                    m_last     = m_code;
                    m_present  = 1'b0;
                    m_gap_left = GAP;
                end
            end else if (m_gap_left > 0) begin
                m_gap_left--;
            end else begin
                pick = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (pick < 0 && m_pend[(m_last + k) % 4]) pick = (m_last + k) % 4;
                end
                if (pick >= 0) begin
                    m_present = 1'b1;
                    m_code    = pick;
                    exp_q.push_back('{code: pick, cyc: cyc});
                end
            end
            m_pend = nxt_pend;
        end
    end

    bit   prev_valid = 1'b0;
    bit   prev_hs    = 1'b0;
    int   n_hs       = 0;
    exp_t e;

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("evt_valid", 32'(bus.evt_valid), 32'(m_present));
            check("evt_code", 32'(bus.evt_code), 32'(m_code));
            check("pend", 32'(bus.pend), 32'(m_pend));
            check("ovf", 32'(bus.ovf), 32'(m_ovf));
            check("busy", 32'(bus.busy), 32'(m_present || (m_gap_left > 0)));
            if (bus.evt_valid && (!prev_valid || prev_hs)) begin
                if (exp_q.size() == 0) begin
                    check("evt_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_code", 32'(bus.evt_code), 32'(e.code));
                    check("sb_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_hs    = bus.evt_valid && bus.evt_ready;
            prev_valid = bus.evt_valid;
            if (prev_hs) n_hs++;
        end
    end

    task automatic step(input logic [3:0] kp, input logic rdy, input logic clr, input logic rst);
        bus.key_pulse = kp;
        bus.evt_ready = rdy;
        bus.ovf_clr   = clr;
        rst_n         = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_before;
        bus.key_pulse = 4'b0;
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        rst_n         = 1'b0;

        repeat (3) step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("rst_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_code", 32'(bus.evt_code), 32'd0);
        check("rst_pend", 32'(bus.pend), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // Single press: event two cycles later, then GAP busy cycles.
        step(4'b0100, 1'b1, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("sp_valid", 32'(bus.evt_valid), 32'd1);
        check("sp_code", 32'(bus.evt_code), 32'd2);
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("sp_pend", 32'(bus.pend), 32'd0);
        check("sp_busy_gap", 32'(bus.busy), 32'd1);
        repeat (GAP - 1) step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("sp_busy_last", 32'(bus.busy), 32'd1);
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("sp_idle", 32'(bus.busy), 32'd0);

        // Simultaneous press after reset: codes 0,1,2,3 in order.
        repeat (2) step(4'b0000, 1'b0, 1'b0, 1'b0);
        hs_before = n_hs;
        step(4'b1111, 1'b1, 1'b0, 1'b1);
        repeat (30) step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("sim_events", 32'(n_hs - hs_before), 32'd4);

        // Backpressure on key 1.
        step(4'b0010, 1'b0, 1'b0, 1'b1);
        repeat (21) step(4'b0000, 1'b0, 1'b0, 1'b1);
        check("bp_valid", 32'(bus.evt_valid), 32'd1);
        check("bp_code", 32'(bus.evt_code), 32'd1);
        hs_before = n_hs;
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("bp_done", 32'(bus.evt_valid), 32'd0);
        repeat (8) step(4'b0000, 1'b0, 1'b0, 1'b1);
        check("bp_one_hs", 32'(n_hs - hs_before), 32'd1);

        // Overflow on key 3, clear racing a new overflow.
        step(4'b1000, 1'b0, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b0, 1'b1);
        check("ovf_set", 32'(bus.ovf), 32'h8);
        step(4'b1000, 1'b0, 1'b1, 1'b1);
        check("ovf_set_wins", 32'(bus.ovf), 32'h8);
        step(4'b0000, 1'b0, 1'b1, 1'b1);
        check("ovf_cleared", 32'(bus.ovf), 32'h0);
        hs_before = n_hs;
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        repeat (8) step(4'b0000, 1'b0, 1'b0, 1'b1);
        check("ovf_single_evt", 32'(n_hs - hs_before), 32'd1);
        check("ovf_pend_empty", 32'(bus.pend), 32'h0);

        // Same-cycle set/clear on key 0.
        step(4'b0001, 1'b1, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("sc_valid", 32'(bus.evt_valid), 32'd1);
        check("sc_code", 32'(bus.evt_code), 32'd0);
        hs_before = n_hs;
        step(4'b0001, 1'b1, 1'b0, 1'b1);
        check("sc_pend", 32'(bus.pend), 32'h1);
        check("sc_ovf", 32'(bus.ovf), 32'h0);
        repeat (10) step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("sc_two_evts", 32'(n_hs - hs_before), 32'd2);

        // Reset while an event is presented.
        step(4'b0100, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        check("mr_valid_before", 32'(bus.evt_valid), 32'd1);
        hs_before = n_hs;
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("mr_valid", 32'(bus.evt_valid), 32'd0);
        check("mr_code", 32'(bus.evt_code), 32'd0);
        check("mr_pend", 32'(bus.pend), 32'd0);
        check("mr_busy", 32'(bus.busy), 32'd0);
        repeat (10) step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("mr_no_evt", 32'(n_hs - hs_before), 32'd0);

        // Random traffic including resets, clears and idle-time ready.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 399) != 0));
        end

        repeat (40) step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_evt_arb.md
KEY_EVT_ARB -- requirements
Module: key_evt_arb

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of key-pulse requesters (fixed at 4 for this release).
REQ-002 SHALL have parameter GAP_CYCLES, default 9000, idle cycles enforced after each accepted event (0 = no gap).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port key_pulse  input  4  one-cycle pulses from upstream debouncers, bit i = key i.
REQ-006 SHALL have port evt_ready  input  1  consumer accepts event this cycle.
REQ-007 SHALL have port ovf_clr  input  1  clears all overflow flags.
REQ-008 SHALL have port evt_valid  output  1  event presented.
REQ-009 SHALL have port evt_code  output  2  index of presented key.
REQ-010 SHALL have port pend  output  4  pending-request flags.
REQ-011 SHALL have port ovf  output  4  sticky overflow flags.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL set pend[i] on the clock after key_pulse[i]=1.
REQ-014 SHALL clear pend[i] on the clock after a handshake (evt_valid & evt_ready) with evt_code==i.
REQ-015 SHALL keep pend[i]=1 when key_pulse[i] and a handshake for key i occur in the same cycle (new press queued).
REQ-016 SHALL set ovf[i] when key_pulse[i]=1 while pend[i]=1 and no handshake for key i that cycle; the press is dropped.
REQ-017 SHALL clear all ovf bits on ovf_clr=1, except that a new overflow in the same cycle sets its bit (set wins).
REQ-018 SHALL implement FSM states IDLE, VALID, GAP.
REQ-019 SHALL, in IDLE with any pend bit set, select a key round-robin and move to VALID on the next clock, loading evt_code.
REQ-020 SHALL search round-robin starting at (last_grant+1) mod 4, ascending with wrap-around; last_grant resets to 3 so key 0 wins first.
REQ-021 SHALL drive evt_valid=1 exactly while in VALID, registered; evt_code SHALL be stable while evt_valid=1.
REQ-022 SHALL stay in VALID until evt_ready=1; on the handshake, update last_grant to evt_code and go to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
REQ-023 SHALL, in GAP, count GAP_CYCLES cycles with a 32-bit counter, then return to IDLE; the counter SHALL be zero outside GAP.
REQ-024 SHALL still latch pend and ovf during VALID and GAP.
REQ-025 SHALL have latency: key_pulse at cycle t with FSM in IDLE and pend empty gives evt_valid=1 at cycle t+2.
REQ-026 SHALL treat evt_ready while evt_valid=0 as don't-care, with no state change.
REQ-027 SHALL recover any illegal FSM encoding to IDLE on the next clock.

Reset
REQ-028 SHALL, on rst_n=0 sampled at a rising edge, set: state IDLE, evt_valid 0, evt_code 0, pend 0, ovf 0, busy 0, gap counter 0, last_grant 3.
REQ-029 SHALL apply reset mid-operation (VALID or GAP): drop the presented event and all pending requests, with no handshake generated.
REQ-030 SHALL ignore key_pulse in any cycle where rst_n=0.

Verification
REQ-031 SHALL cover single press: key_pulse=0100 at t, evt_ready=1 -> evt_valid=1, evt_code=2 at t+2; pend=0000 at t+3; busy for GAP_CYCLES more cycles.
REQ-032 SHALL cover simultaneous press: key_pulse=1111 after reset, evt_ready always 1, GAP_CYCLES=4 -> codes 0,1,2,3 in order, each separated by 4 idle cycles.
REQ-033 SHALL cover backpressure: evt_ready=0 for 20 cycles with key 1 presented -> evt_valid and evt_code=1 held stable; then evt_ready=1 gives one handshake.
REQ-034 SHALL cover overflow: pulse key 3 twice while it is still pending -> ovf=1000, single event; ovf_clr together with a third overflow keeps ovf[3]=1.
REQ-035 SHALL cover same-cycle set/clear: key_pulse[0]=1 in the handshake cycle of key 0 -> pend[0] stays 1, ovf[0]=0, a second event for key 0 follows.
REQ-036 SHALL cover mid-operation reset: rst_n=0 for 1 cycle during VALID -> all outputs at reset values on the next cycle, no event issued.
